// File: rtl/mips_store_checker_if.sv
// Snoop and control bundle for mips_store_checker.
//   Snooped bus : CS, WE, Address, Mem_Bus (observed only, never driven)
//   Control     : Start, Exp_WE, Exp_Idx, Exp_Data, Exp_Addr
//   Results     : Busy, Done, Pass, Timed_Out, Err_Count, Fail_Valid,
//                 First_Fail_Idx, First_Fail_Data, Store_Idx
// slave  = checker side (bus/control in, results out)
// master = driver/monitor side (bus/control out, results in)
interface mips_store_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int IDX_W  = 4
);
  logic              CS;
  logic              WE;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Mem_Bus;
  logic              Start;
  logic              Exp_WE;
  logic [IDX_W-1:0]  Exp_Idx;
  logic [DATA_W-1:0] Exp_Data;
  logic [ADDR_W-1:0] Exp_Addr;
  logic              Busy;
  logic              Done;
  logic              Pass;
  logic              Timed_Out;
  logic [IDX_W-1:0]  Err_Count;
  logic              Fail_Valid;
  logic [IDX_W-1:0]  First_Fail_Idx;
  logic [DATA_W-1:0] First_Fail_Data;
  logic [IDX_W-1:0]  Store_Idx;

  modport slave (
    input  CS, WE, Address, Mem_Bus, Start, Exp_WE, Exp_Idx, Exp_Data, Exp_Addr,
    output Busy, Done, Pass, Timed_Out, Err_Count, Fail_Valid,
           First_Fail_Idx, First_Fail_Data, Store_Idx
  );

  modport master (
    output CS, WE, Address, Mem_Bus, Start, Exp_WE, Exp_Idx, Exp_Data, Exp_Addr,
    input  Busy, Done, Pass, Timed_Out, Err_Count, Fail_Valid,
           First_Fail_Idx, First_Fail_Data, Store_Idx
  );
endinterface

// File: rtl/mips_store_checker.sv
// Store-word checker: snoops the CPU-to-memory bus, captures each store
// (rising edge of CS&WE) in order and compares it with a programmable table
// of expected data (and optionally addresses). Reports pass/fail, error
// count, first failing index/data and an idle timeout.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - mips_store_checker_if.slave (snooped bus, table programming, results)
module mips_store_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 7,
  parameter int N          = 10,
  parameter int IDX_W      = $clog2(N+1),
  parameter int CHECK_ADDR = 0,
  parameter int TIMEOUT    = 1024
) (
  input logic CLK,
  input logic RST,
  mips_store_checker_if.slave bus
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t              state, state_n;
  logic                ev_prev;
  logic [IDX_W-1:0]    err_q, err_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                fv_q, fv_n;
  logic [IDX_W-1:0]    ffi_q, ffi_n;
  logic [DATA_W-1:0]   ffd_q, ffd_n;
  logic                to_q, to_n;
  logic [TO_W-1:0]     cnt_q, cnt_n;

  // Expected table: not reset, survives RST
  logic [N-1:0][DATA_W-1:0] exp_data;
  logic [N-1:0][ADDR_W-1:0] exp_addr;

  logic store_ev, mismatch;

  // A store is the first cycle of a CS&WE pulse; long pulses count once
  assign store_ev = bus.CS & bus.WE & ~ev_prev;

  // idx_q < N whenever ARMED, so the table read is always in range there
  assign mismatch = (bus.Mem_Bus != exp_data[idx_q]) |
                    ((CHECK_ADDR != 0) && (bus.Address != exp_addr[idx_q]));

  always_ff @(posedge CLK) begin
    if (bus.Exp_WE && state != ARMED && bus.Exp_Idx < IDX_W'(N)) begin
      exp_data[bus.Exp_Idx] <= bus.Exp_Data;
      exp_addr[bus.Exp_Idx] <= bus.Exp_Addr;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      ev_prev <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      ffd_q   <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      ev_prev <= bus.CS & bus.WE;
      err_q   <= err_n;
      idx_q   <= idx_n;
      fv_q    <= fv_n;
      ffi_q   <= ffi_n;
      ffd_q   <= ffd_n;
      to_q    <= to_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    idx_n   = idx_q;
    fv_n    = fv_q;
    ffi_n   = ffi_q;
    ffd_n   = ffd_q;
    to_n    = to_q;
    cnt_n   = cnt_q;
    if (bus.Start) begin
      // Start wins over everything, including a same-cycle store in ARMED
      state_n = ARMED;
      err_n   = '0;
      idx_n   = '0;
      fv_n    = 1'b0;
      ffi_n   = '0;
      ffd_n   = '0;
      to_n    = 1'b0;
      cnt_n   = '0;
    end else if (state == ARMED) begin
      if (store_ev) begin
        cnt_n = '0;
        if (mismatch) begin
          err_n = err_q + IDX_W'(1);
          if (!fv_q) begin
            fv_n  = 1'b1;
            ffi_n = idx_q;
            ffd_n = bus.Mem_Bus;
          end
        end
        idx_n = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N-1)) state_n = DONE;
      end else if (TIMEOUT > 0) begin
        if (cnt_q == TO_W'(TIMEOUT-1)) begin
          state_n = DONE;
          to_n    = 1'b1;
        end else begin
          cnt_n = cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign bus.Busy            = (state == ARMED);
  assign bus.Done            = (state == DONE);
  assign bus.Pass            = (state == DONE) && (err_q == '0) && !to_q;
  assign bus.Timed_Out       = to_q;
  assign bus.Err_Count       = err_q;
  assign bus.Fail_Valid      = fv_q;
  assign bus.First_Fail_Idx  = ffi_q;
  assign bus.First_Fail_Data = ffd_q;
  assign bus.Store_Idx       = idx_q;

endmodule

// File: tb/tb_mips_store_checker.sv
module tb_mips_store_checker;
  localparam int DW = 32, AW = 7, NN = 10, IW = 4, TO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mips_store_checker_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) bus();

  mips_store_checker #(.DATA_W(DW), .ADDR_W(AW), .N(NN), .IDX_W(IW),
                       .CHECK_ADDR(1), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .bus(bus));

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] e_idx;
    logic [IW-1:0] e_err;
    logic          e_fv;
    logic [IW-1:0] e_ffi;
  } vec_t;

  logic [DW-1:0] exp_d [NN];
  logic [AW-1:0] exp_a [NN];
  vec_t          bad_run [NN];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Drive a store starting at a negedge; returns on a negedge after hold+gap cycles
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold, input int gap);
    bus.CS = 1'b1; bus.WE = 1'b1; bus.Address = a; bus.Mem_Bus = d;
    cyc(hold);
    bus.CS = 1'b0; bus.WE = 1'b0;
    cyc(gap);
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1;
    cyc(1);
    bus.Start = 1'b0;
  endtask

  task automatic good_run(input string tag);
    for (int i = 0; i < NN; i++) begin
      store(exp_a[i], exp_d[i], 1, 1);
      chk({tag, "_idx"}, bus.Store_Idx, i + 1);
      chk({tag, "_err"}, bus.Err_Count, 0);
    end
    chk({tag, "_done"}, bus.Done, 1);
    chk({tag, "_pass"}, bus.Pass, 1);
    chk({tag, "_busy"}, bus.Busy, 0);
    chk({tag, "_fv"}, bus.Fail_Valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_d = '{32'h6, 32'h12, 32'h18, 32'hC, 32'h2, 32'h16, 32'h1, 32'h120, 32'h3, 32'h00412022};
    for (int i = 0; i < NN; i++) exp_a[i] = AW'(7'd20 + 7'(i));
    // Store #5 (index 4) carries 0xD instead of 2
    bad_run = '{
      '{7'd20, 32'h6,        4'd1,  4'd0, 1'b0, 4'd0},
      '{7'd21, 32'h12,       4'd2,  4'd0, 1'b0, 4'd0},
      '{7'd22, 32'h18,       4'd3,  4'd0, 1'b0, 4'd0},
      '{7'd23, 32'hC,        4'd4,  4'd0, 1'b0, 4'd0},
      '{7'd24, 32'hD,        4'd5,  4'd1, 1'b1, 4'd4},
      '{7'd25, 32'h16,       4'd6,  4'd1, 1'b1, 4'd4},
      '{7'd26, 32'h1,        4'd7,  4'd1, 1'b1, 4'd4},
      '{7'd27, 32'h120,      4'd8,  4'd1, 1'b1, 4'd4},
      '{7'd28, 32'h3,        4'd9,  4'd1, 1'b1, 4'd4},
      '{7'd29, 32'h00412022, 4'd10, 4'd1, 1'b1, 4'd4}};

    bus.CS = 0; bus.WE = 0; bus.Address = '0; bus.Mem_Bus = '0; bus.Start = 0;
    bus.Exp_WE = 0; bus.Exp_Idx = '0; bus.Exp_Data = '0; bus.Exp_Addr = '0;

    // Reset state
    cyc(3);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_pass", bus.Pass, 0);
    chk("rst_idx", bus.Store_Idx, 0);
    chk("rst_err", bus.Err_Count, 0);
    RST = 1'b1;
    cyc(1);

    // Load table
    for (int i = 0; i < NN; i++) begin
      bus.Exp_WE = 1; bus.Exp_Idx = IW'(i); bus.Exp_Data = exp_d[i]; bus.Exp_Addr = exp_a[i];
      cyc(1);
    end
    bus.Exp_WE = 0;
    // Stores while IDLE are ignored
    store(exp_a[0], exp_d[0], 1, 1);
    chk("idle_store_idx", bus.Store_Idx, 0);
    chk("idle_busy", bus.Busy, 0);

    // All-good run
    start_pulse();
    chk("start_busy", bus.Busy, 1);
    chk("start_done", bus.Done, 0);
    good_run("good");
    store(exp_a[0], exp_d[0], 1, 1);
    chk("done_store_idx", bus.Store_Idx, 10);
    chk("done_still", bus.Done, 1);

    // Bad store at index 4, table-driven
    start_pulse();
    chk("restart_idx", bus.Store_Idx, 0);
    chk("restart_done", bus.Done, 0);
    for (int i = 0; i < NN; i++) begin
      store(bad_run[i].addr, bad_run[i].data, 1, 1);
      chk($sformatf("bad%0d_idx", i), bus.Store_Idx, bad_run[i].e_idx);
      chk($sformatf("bad%0d_err", i), bus.Err_Count, bad_run[i].e_err);
      chk($sformatf("bad%0d_fv", i), bus.Fail_Valid, bad_run[i].e_fv);
      chk($sformatf("bad%0d_ffi", i), bus.First_Fail_Idx, bad_run[i].e_ffi);
    end
    chk("bad_ffd", bus.First_Fail_Data, 32'hD);
    chk("bad_done", bus.Done, 1);
    chk("bad_pass", bus.Pass, 0);

    // Long pulses: 3 cycles high, 2 low, each counts once
    start_pulse();
    chk("hold_clear_fv", bus.Fail_Valid, 0);
    for (int i = 0; i < 4; i++) begin
      bus.CS = 1; bus.WE = 1; bus.Address = exp_a[i]; bus.Mem_Bus = exp_d[i];
      cyc(1);
      chk($sformatf("hold%0d_first", i), bus.Store_Idx, i + 1);
      cyc(2);
      chk($sformatf("hold%0d_held", i), bus.Store_Idx, i + 1);
      bus.CS = 0; bus.WE = 0;
      cyc(2);
    end
    chk("hold_err", bus.Err_Count, 0);

    // Start with a same-cycle store: store discarded
    bus.Start = 1; bus.CS = 1; bus.WE = 1; bus.Address = exp_a[4]; bus.Mem_Bus = exp_d[4];
    cyc(1);
    bus.Start = 0; bus.CS = 0; bus.WE = 0;
    chk("startpri_idx", bus.Store_Idx, 0);
    chk("startpri_err", bus.Err_Count, 0);
    cyc(1);
    store(exp_a[0], exp_d[0], 1, 1);
    chk("startpri_next_idx", bus.Store_Idx, 1);
    chk("startpri_next_err", bus.Err_Count, 0);

    // Timeout: 3 stores then idle, Done exactly TO cycles after the 3rd event
    start_pulse();
    store(exp_a[0], exp_d[0], 1, 1);
    store(exp_a[1], exp_d[1], 1, 1);
    store(exp_a[2], exp_d[2], 1, 0);
    for (int j = 1; j < TO; j++) begin
      cyc(1);
      if (j == 1) bus.CS = 0;
      if (j == TO - 1) chk("to_not_yet", bus.Done, 0);
    end
    cyc(1);
    chk("to_done", bus.Done, 1);
    chk("to_flag", bus.Timed_Out, 1);
    chk("to_pass", bus.Pass, 0);
    chk("to_idx", bus.Store_Idx, 3);
    chk("to_busy", bus.Busy, 0);

    // Address check; table write while ARMED ignored
    start_pulse();
    chk("addr_clear_to", bus.Timed_Out, 0);
    store(7'd99, exp_d[0], 1, 1);
    chk("addr_err", bus.Err_Count, 1);
    chk("addr_fv", bus.Fail_Valid, 1);
    chk("addr_ffi", bus.First_Fail_Idx, 0);
    bus.Exp_WE = 1; bus.Exp_Idx = 4'd1; bus.Exp_Data = 32'hDEAD; bus.Exp_Addr = 7'd5;
    cyc(1);
    bus.Exp_WE = 0;
    store(exp_a[1], exp_d[1], 1, 1);
    chk("armed_wr_ignored", bus.Err_Count, 1);
    chk("addr_ffi_kept", bus.First_Fail_Idx, 0);

    // Async reset mid-run, then a clean run on the retained table
    start_pulse();
    for (int i = 0; i < 6; i++) store(exp_a[i], exp_d[i], 1, 1);
    chk("pre_rst_idx", bus.Store_Idx, 6);
    #1 RST = 1'b0;
    #1;
    chk("arst_busy", bus.Busy, 0);
    chk("arst_idx", bus.Store_Idx, 0);
    chk("arst_done", bus.Done, 0);
    cyc(1);
    RST = 1'b1;
    cyc(1);
    start_pulse();
    good_run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
